instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_pkg.sv | 19 +
 rtl/instr_fetch_buf.sv | 36 +++
 rtl/instr_fetch.sv | 89 ++++++++
 3 files changed

// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: shared cpu encodings for next-PC select, fetch FSM states and reset PC
package instr_fetch_pkg;

   typedef enum logic [1:0] {
      PC_SEQ  = 2'b00,
      PC_REL  = 2'b01,
      PC_ABS  = 2'b10,
      PC_HOLD = 2'b11
   } pc_mux_t;

   typedef enum logic [1:0] {
      ST_LOOKUP  = 2'b00,
      ST_FETCH   = 2'b01,
      ST_PRESENT = 2'b10
   } state_t;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_buf.sv
// fetch_buf: one-word instruction buffer with word-tag compare and halfword select
module fetch_buf
   import instr_fetch_pkg::*;
#(
   parameter int ADDR_W = 32
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_load,
   input  logic [31:0]       i_data,
   input  logic [ADDR_W-1:1] i_pc,
   output logic              o_hit,
   output logic [15:0]       o_instr
);

   logic [31:0]       r_data;
   logic [ADDR_W-3:0] r_tag;
   logic              r_valid;

   // capture the acknowledged memory word together with the word address it came from
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data  <= '0;
         r_tag   <= '0;
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_data  <= i_data;
         r_tag   <= i_pc[ADDR_W-1:2];
         r_valid <= 1'b1;
      end
   end

   assign o_hit   = r_valid && (r_tag == i_pc[ADDR_W-1:2]);
   assign o_instr = i_pc[1] ? r_data[31:16] : r_data[15:0];

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: 16-bit instruction fetch unit with one-word buffer and next-PC select
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(instr_fetch_pkg::RESET_PC)
)(
   input  logic              clk,
   input  logic              rst_n,
   output logic [ADDR_W-1:0] IMEM_ADR_O,
   output logic              IMEM_STB_O,
   input  logic              IMEM_ACK_I,
   input  logic [31:0]       IMEM_DAT_I,
   output logic [15:0]       instr,
   output logic              INSTR_VALID,
   input  logic              INSTR_READY,
   input  logic [1:0]        PC_MUX,
   input  logic [ADDR_W-1:0] PC_REL,
   input  logic [ADDR_W-1:0] PC_ABS,
   output logic [ADDR_W-1:0] PC
);

   state_t            r_state;
   logic [ADDR_W-1:0] r_pc;
   logic              r_stb;
   logic              r_vld;
   logic [ADDR_W-1:0] w_target;
   logic [ADDR_W-1:0] w_next_pc;
   logic              w_hit;
   logic              w_load;

   assign w_load      = (r_state == ST_FETCH) && IMEM_ACK_I;
   assign IMEM_ADR_O  = {r_pc[ADDR_W-1:2], 2'b00};
   assign IMEM_STB_O  = r_stb;
   assign INSTR_VALID = r_vld;
   assign PC          = r_pc;

   fetch_buf #(.ADDR_W(ADDR_W)) u_buf (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_load),
      .i_data  (IMEM_DAT_I),
      .i_pc    (r_pc[ADDR_W-1:1]),
      .o_hit   (w_hit),
      .o_instr (instr)
   );

   // next-PC candidate, halfword aligned, wrapping modulo 2^ADDR_W
   always_comb begin
      w_target  = (PC_MUX == instr_fetch_pkg::PC_SEQ) ? r_pc + ADDR_W'(2) :
                  (PC_MUX == instr_fetch_pkg::PC_REL) ? r_pc + PC_REL :
                  (PC_MUX == instr_fetch_pkg::PC_ABS) ? PC_ABS : r_pc;
      w_next_pc = {w_target[ADDR_W-1:1], 1'b0};
   end

   // fetch FSM: lookup decides hit or bus fetch, present holds until consumed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_LOOKUP;
         r_pc    <= RESET_PC;
         r_stb   <= 1'b0;
         r_vld   <= 1'b0;
      end else begin
         case (r_state)
            ST_LOOKUP: begin
               r_state <= w_hit ? ST_PRESENT : ST_FETCH;
               r_stb   <= !w_hit;
               r_vld   <= w_hit;
            end
            ST_FETCH: if (IMEM_ACK_I) begin
               r_state <= ST_PRESENT;
               r_stb   <= 1'b0;
               r_vld   <= 1'b1;
            end
            ST_PRESENT: if (INSTR_READY) begin
               r_state <= ST_LOOKUP;
               r_vld   <= 1'b0;
               r_pc    <= w_next_pc;
            end
            default: begin
               r_state <= ST_LOOKUP;
               r_stb   <= 1'b0;
               r_vld   <= 1'b0;
            end
         endcase
      end
   end

endmodule
